// File: rtl/mig_dma_app_pkg.sv
// Shared types for the bsg_cache DMA to MIG native app interface adapter.
package mig_dma_app_pkg;

    localparam int dma_caddr_width_gp = 32;

    typedef struct packed {
        logic                          write_not_read;
        logic [dma_caddr_width_gp-1:0] addr;
    } dma_pkt_s;

    typedef enum logic [2:0] {
        e_idle,
        e_wr_fill,
        e_wr_drain,
        e_rd_req,
        e_rd_send
    } state_e;

    typedef enum logic [2:0] {
        e_mig_cmd_write = 3'b000,
        e_mig_cmd_read  = 3'b001
    } mig_cmd_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load init+1.
module bsg_counter_clear_up #(
    parameter int max_val_p  = 8,
    parameter int init_val_p = 0,
    parameter int width_lp   = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_o <= width_lp'(init_val_p);
        else if (clear_i)
            count_o <= width_lp'(init_val_p) + width_lp'(up_i);
        else if (up_i)
            count_o <= count_o + width_lp'(1);
    end

endmodule

// File: rtl/mig_dma_app_adapter.sv
// Block-at-a-time bridge from bsg_cache DMA (packet/fill/evict) to MIG DDR3 app
// commands; the full block is gathered locally before either side is driven.
module mig_dma_app_adapter
    import mig_dma_app_pkg::*;
#(
    parameter int caddr_width_p    = dma_caddr_width_gp,
    parameter int dma_data_width_p = 64,
    parameter int block_width_p    = 512,
    parameter int app_data_width_p = 128,
    parameter int app_addr_width_p = 28,
    parameter int dq_width_p       = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          init_calib_complete_i,
    input  logic [caddr_width_p:0]        dma_pkt_i,
    input  logic                          dma_pkt_v_i,
    output logic                          dma_pkt_yumi_o,
    output logic [dma_data_width_p-1:0]   dma_data_o,
    output logic                          dma_data_v_o,
    input  logic                          dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0]   dma_data_i,
    input  logic                          dma_data_v_i,
    output logic                          dma_data_yumi_o,
    output logic [app_addr_width_p-1:0]   app_addr_o,
    output logic [2:0]                    app_cmd_o,
    output logic                          app_en_o,
    input  logic                          app_rdy_i,
    output logic [app_data_width_p-1:0]   app_wdf_data_o,
    output logic [app_data_width_p/8-1:0] app_wdf_mask_o,
    output logic                          app_wdf_wren_o,
    output logic                          app_wdf_end_o,
    input  logic                          app_wdf_rdy_i,
    input  logic [app_data_width_p-1:0]   app_rd_data_i,
    input  logic                          app_rd_data_valid_i,
    output logic                          error_o
);

    localparam int dma_beats_lp  = block_width_p / dma_data_width_p;
    localparam int app_beats_lp  = block_width_p / app_data_width_p;
    localparam int lg_dq_bytes_lp = $clog2(dq_width_p / 8);
    localparam int app_step_lp   = app_data_width_p / dq_width_p;
    localparam int dma_cnt_w_lp  = $clog2(dma_beats_lp);
    localparam int app_cnt_w_lp  = $clog2(app_beats_lp + 1);
    localparam int app_idx_w_lp  = $clog2(app_beats_lp);

    localparam logic [dma_cnt_w_lp-1:0] dma_last_lp = dma_cnt_w_lp'(dma_beats_lp - 1);
    localparam logic [app_cnt_w_lp-1:0] app_full_lp = app_cnt_w_lp'(app_beats_lp);
    localparam logic [app_idx_w_lp-1:0] app_last_lp = app_idx_w_lp'(app_beats_lp - 1);

    dma_pkt_s                   pkt;
    state_e                     state_r, state_n;
    logic [caddr_width_p-1:0]   blk_addr;
    logic [app_addr_width_p-1:0] base_r;
    logic [block_width_p-1:0]   block_r;
    logic                       error_r;

    logic [dma_cnt_w_lp-1:0]    j_cnt;
    logic [app_cnt_w_lp-1:0]    c_cnt, w_cnt;
    logic [app_idx_w_lp-1:0]    r_cnt;
    logic                       cnt_clear, j_up, rd_capture, dma_send;

    assign pkt      = dma_pkt_i;
    assign blk_addr = pkt.addr & ~caddr_width_p'(block_width_p / 8 - 1);

    assign cnt_clear  = (state_r == e_idle);
    assign rd_capture = (state_r == e_rd_req) & app_rd_data_valid_i;
    assign dma_send   = dma_data_v_o & dma_data_ready_and_i;
    assign j_up       = dma_data_yumi_o | dma_send;

    bsg_counter_clear_up #(.max_val_p(dma_beats_lp - 1)) j_counter (
        .clk_i, .reset_i, .clear_i(cnt_clear), .up_i(j_up), .count_o(j_cnt));
    bsg_counter_clear_up #(.max_val_p(app_beats_lp)) c_counter (
        .clk_i, .reset_i, .clear_i(cnt_clear), .up_i(app_en_o & app_rdy_i), .count_o(c_cnt));
    bsg_counter_clear_up #(.max_val_p(app_beats_lp)) w_counter (
        .clk_i, .reset_i, .clear_i(cnt_clear), .up_i(app_wdf_wren_o & app_wdf_rdy_i), .count_o(w_cnt));
    bsg_counter_clear_up #(.max_val_p(app_beats_lp - 1)) r_counter (
        .clk_i, .reset_i, .clear_i(cnt_clear), .up_i(rd_capture), .count_o(r_cnt));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            base_r  <= '0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (dma_pkt_yumi_o)
                base_r <= app_addr_width_p'(blk_addr >> lg_dq_bytes_lp);
            // MIG read data has no backpressure, so anything unexpected is lost
            if (app_rd_data_valid_i && state_r != e_rd_req)
                error_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (dma_data_yumi_o)
            block_r[int'(j_cnt)*dma_data_width_p +: dma_data_width_p] <= dma_data_i;
        else if (rd_capture)
            block_r[int'(r_cnt)*app_data_width_p +: app_data_width_p] <= app_rd_data_i;
    end

    always_comb begin
        state_n         = state_r;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        dma_data_v_o    = 1'b0;
        app_en_o        = 1'b0;
        app_cmd_o       = e_mig_cmd_write;
        app_wdf_wren_o  = 1'b0;
        case (state_r)
            e_idle: begin
                dma_pkt_yumi_o = dma_pkt_v_i & init_calib_complete_i;
                if (dma_pkt_yumi_o)
                    state_n = pkt.write_not_read ? e_wr_fill : e_rd_req;
            end
            e_wr_fill: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i && j_cnt == dma_last_lp)
                    state_n = e_wr_drain;
            end
            e_wr_drain: begin
                // command and data channels drain independently
                app_en_o       = (c_cnt != app_full_lp);
                app_wdf_wren_o = (w_cnt != app_full_lp);
                if (c_cnt == app_full_lp && w_cnt == app_full_lp)
                    state_n = e_idle;
            end
            e_rd_req: begin
                app_en_o  = (c_cnt != app_full_lp);
                app_cmd_o = e_mig_cmd_read;
                if (app_rd_data_valid_i && r_cnt == app_last_lp)
                    state_n = e_rd_send;
            end
            e_rd_send: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_and_i && j_cnt == dma_last_lp)
                    state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    assign app_addr_o     = base_r + app_addr_width_p'(int'(c_cnt) * app_step_lp);
    assign app_wdf_data_o = block_r[int'(w_cnt[app_idx_w_lp-1:0])*app_data_width_p +: app_data_width_p];
    assign app_wdf_mask_o = '0;
    assign app_wdf_end_o  = app_wdf_wren_o;
    assign dma_data_o     = block_r[int'(j_cnt)*dma_data_width_p +: dma_data_width_p];
    assign error_o        = error_r;

endmodule

// File: tb/tb_mig_dma_app_adapter.sv
// Directed bench: stimulus pushes expected MIG commands, write beats and fill
// beats into queues; a negedge monitor pops and compares on each handshake.
module tb_mig_dma_app_adapter;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         init_calib_complete_i;
    logic [32:0]  dma_pkt_i;
    logic         dma_pkt_v_i;
    logic         dma_pkt_yumi_o;
    logic [63:0]  dma_data_o;
    logic         dma_data_v_o;
    logic         dma_data_ready_and_i;
    logic [63:0]  dma_data_i;
    logic         dma_data_v_i;
    logic         dma_data_yumi_o;
    logic [27:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o;
    logic         app_rdy_i;
    logic [127:0] app_wdf_data_o;
    logic [15:0]  app_wdf_mask_o;
    logic         app_wdf_wren_o;
    logic         app_wdf_end_o;
    logic         app_wdf_rdy_i;
    logic [127:0] app_rd_data_i;
    logic         app_rd_data_valid_i;
    logic         error_o;

    mig_dma_app_adapter dut (
        .clk_i(clk_i), .reset_i(reset_i), .init_calib_complete_i(init_calib_complete_i),
        .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
        .dma_data_ready_and_i(dma_data_ready_and_i), .dma_data_i(dma_data_i),
        .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
        .app_rdy_i(app_rdy_i), .app_wdf_data_o(app_wdf_data_o),
        .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_wren_o(app_wdf_wren_o),
        .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i),
        .error_o(error_o));

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int mon_cmd_n = 0;
    int mon_wdf_n = 0;

    logic [30:0]  exp_cmd_q[$];
    logic [127:0] exp_wdf_q[$];
    logic [63:0]  exp_dma_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // monitor: compares every handshake against the scoreboard
    logic        prev_v = 1'b0, prev_rdy = 1'b0;
    logic [63:0] prev_data = '0;
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (app_en_o && app_rdy_i) begin
                mon_cmd_n++;
                if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 128'(app_addr_o), 128'h0);
                else chk("app_cmd_addr", 128'({app_cmd_o, app_addr_o}), 128'(exp_cmd_q.pop_front()));
            end
            if (app_wdf_wren_o) begin
                chk("wdf_mask_end", 128'({app_wdf_mask_o, app_wdf_end_o}), 128'({16'h0, 1'b1}));
                if (app_wdf_rdy_i) begin
                    mon_wdf_n++;
                    if (exp_wdf_q.size() == 0) chk("wdf_unexpected", app_wdf_data_o, 128'h0);
                    else chk("wdf_data", app_wdf_data_o, exp_wdf_q.pop_front());
                end
            end
            if (dma_data_v_o) begin
                if (prev_v && !prev_rdy) chk("dma_hold", 128'(dma_data_o), 128'(prev_data));
                if (dma_data_ready_and_i) begin
                    if (exp_dma_q.size() == 0) chk("dma_unexpected", 128'(dma_data_o), 128'h0);
                    else chk("dma_data", 128'(dma_data_o), 128'(exp_dma_q.pop_front()));
                end
            end
        end
        prev_v    = dma_data_v_o;
        prev_rdy  = dma_data_ready_and_i;
        prev_data = dma_data_o;
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic send_pkt(input logic wnr, input logic [31:0] addr);
        int n = 0;
        dma_pkt_i   = {wnr, addr};
        dma_pkt_v_i = 1'b1;
        #1;
        while (!dma_pkt_yumi_o && n < 50) begin tick(); n++; end
        chk("pkt_yumi", 128'(dma_pkt_yumi_o), 128'h1);
        tick();
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic fill(input logic [63:0] d [8], input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            dma_data_i   = d[i];
            dma_data_v_i = 1'b1;
            #1;
            chk("fill_yumi", 128'(dma_data_yumi_o), 128'h1);
            tick();
        end
        dma_data_v_i = 1'b0;
    endtask

    task automatic rd_return(input logic [63:0] d [8]);
        for (int k = 0; k < 4; k++) begin
            app_rd_data_i       = {d[2*k+1], d[2*k]};
            app_rd_data_valid_i = 1'b1;
            tick();
        end
        app_rd_data_valid_i = 1'b0;
        chk("first_fill_valid", 128'(dma_data_v_o), 128'h1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_cmd_q.size() + exp_wdf_q.size() + exp_dma_q.size()) != 0 && n < 200) begin
            tick(); n++;
        end
        chk(name, 128'(exp_cmd_q.size() + exp_wdf_q.size() + exp_dma_q.size()), 128'h0);
        tick(); tick();
    endtask

    task automatic chk_quiet(input string name);
        chk(name, 128'({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, app_en_o,
                        app_wdf_wren_o, app_wdf_end_o, error_o}), 128'h0);
    endtask

    logic [63:0] wd0 [8] = '{64'h0, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7};
    logic [63:0] wd1 [8] = '{64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'hC4, 64'hC5, 64'hC6, 64'hC7};
    logic [63:0] rd0 [8] = '{64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908,
                             64'h1716_1514_1312_1110, 64'h1F1E_1D1C_1B1A_1918,
                             64'h2726_2524_2322_2120, 64'h2F2E_2D2C_2B2A_2928,
                             64'h3736_3534_3332_3130, 64'h3F3E_3D3C_3B3A_3938};
    logic [63:0] rd1 [8] = '{64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                             64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003,
                             64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0005,
                             64'hDEAD_0000_0000_0006, 64'hDEAD_0000_0000_0007};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; init_calib_complete_i = 1'b0;
        dma_pkt_i = '0; dma_pkt_v_i = 1'b0; dma_data_ready_and_i = 1'b1;
        dma_data_i = '0; dma_data_v_i = 1'b0; app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1;
        app_rd_data_i = '0; app_rd_data_valid_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        chk_quiet("reset_state");

        // uncalibrated: packet must wait, then yumi the cycle calibration rises
        dma_pkt_i = {1'b1, 32'h0000_0000}; dma_pkt_v_i = 1'b1;
        repeat (3) tick();
        chk("no_yumi_uncal", 128'(dma_pkt_yumi_o), 128'h0);
        init_calib_complete_i = 1'b1;
        #1;
        chk("yumi_on_cal", 128'(dma_pkt_yumi_o), 128'h1);
        exp_cmd_q = '{{3'b000, 28'h000_0000}, {3'b000, 28'h000_0008},
                      {3'b000, 28'h000_0010}, {3'b000, 28'h000_0018}};
        exp_wdf_q = '{{64'h1, 64'h0}, {64'h3, 64'h2}, {64'h5, 64'h4}, {64'h7, 64'h6}};
        tick();
        dma_pkt_v_i = 1'b0;
        fill(wd0, 8);
        wait_drain("write0_drain");
        chk_quiet("write0_idle");

        // commands stalled: data drains first
        app_rdy_i = 1'b0;
        mon_cmd_n = 0; mon_wdf_n = 0;
        exp_cmd_q = '{{3'b000, 28'h000_0080}, {3'b000, 28'h000_0088},
                      {3'b000, 28'h000_0090}, {3'b000, 28'h000_0098}};
        exp_wdf_q = '{{64'hC1, 64'hC0}, {64'hC3, 64'hC2}, {64'hC5, 64'hC4}, {64'hC7, 64'hC6}};
        send_pkt(1'b1, 32'h0000_0100);
        fill(wd1, 8);
        repeat (10) tick();
        chk("data_first_wdf", 128'(mon_wdf_n), 128'd4);
        chk("data_first_cmd", 128'(mon_cmd_n), 128'd0);
        app_rdy_i = 1'b1;
        wait_drain("write1_drain");
        chk("write1_cmd_count", 128'(mon_cmd_n), 128'd4);

        // read, always-ready fill side
        exp_cmd_q = '{{3'b001, 28'h000_0020}, {3'b001, 28'h000_0028},
                      {3'b001, 28'h000_0030}, {3'b001, 28'h000_0038}};
        exp_dma_q = '{64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908,
                      64'h1716_1514_1312_1110, 64'h1F1E_1D1C_1B1A_1918,
                      64'h2726_2524_2322_2120, 64'h2F2E_2D2C_2B2A_2928,
                      64'h3736_3534_3332_3130, 64'h3F3E_3D3C_3B3A_3938};
        send_pkt(1'b0, 32'h8000_0040);
        tick();
        rd_return(rd0);
        wait_drain("read0_drain");

        // read with ready toggling 1,0
        exp_cmd_q = '{{3'b001, 28'h000_0800}, {3'b001, 28'h000_0808},
                      {3'b001, 28'h000_0810}, {3'b001, 28'h000_0818}};
        exp_dma_q = '{64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                      64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003,
                      64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0005,
                      64'hDEAD_0000_0000_0006, 64'hDEAD_0000_0000_0007};
        send_pkt(1'b0, 32'h0000_1000);
        tick(); tick();
        rd_return(rd1);
        for (int n = 0; n < 60 && exp_dma_q.size() != 0; n++) begin
            dma_data_ready_and_i = (n % 2 == 0);
            tick();
        end
        dma_data_ready_and_i = 1'b1;
        wait_drain("read1_drain");

        // reset mid-fill abandons the transaction
        send_pkt(1'b1, 32'h0000_0040);
        fill(wd0, 3);
        reset_i = 1'b1; dma_data_v_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk_quiet("reset_midfill_idle");
        dma_data_v_i = 1'b0;
        tick();

        // stray read data in idle sets the sticky error
        app_rd_data_valid_i = 1'b1;
        tick();
        app_rd_data_valid_i = 1'b0;
        chk("error_set", 128'(error_o), 128'h1);
        repeat (3) tick();
        chk("error_sticky", 128'(error_o), 128'h1);
        chk("no_stray_cmds", 128'(exp_cmd_q.size() + exp_wdf_q.size() + exp_dma_q.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mig_dma_app_adapter.md
Name: mig_dma_app_adapter

Overview:
- Converts the bsg_cache DMA interface (packet, fill-data in, evict-data out) into the MIG DDR3 native app interface (app_cmd/app_wdf/app_rd).
- Sits inside the DRAM controller, downstream of the core's DMA port, in the MIG ui clock domain after the clock-crossing FIFOs.
- Handles one block transaction at a time.
- Gathers a full block in an internal buffer before issuing MIG writes, or before returning read data.

Parameters:
caddr_width_p, 32, DMA packet address width (bytes)
dma_data_width_p, 64, DMA data beat width (l2_fill_width)
block_width_p, 512, cache block width
app_data_width_p, 128, MIG app data width (one command per beat, 4:1 mode, BL8)
app_addr_width_p, 28, MIG app_addr width
dq_width_p, 16, DDR3 DQ width; app_addr unit = dq_width_p/8 bytes

Ports:
clk_i  in  1  ui clock
reset_i  in  1  synchronous active-high reset
init_calib_complete_i  in  1  MIG calibration done
dma_pkt_i  in  caddr_width_p+1  {write_not_read, addr}
dma_pkt_v_i  in  1  packet valid
dma_pkt_yumi_o  out  1  packet consumed
dma_data_o  out  dma_data_width_p  read fill beat
dma_data_v_o  out  1  fill beat valid
dma_data_ready_and_i  in  1  fill beat accepted
dma_data_i  in  dma_data_width_p  evict beat
dma_data_v_i  in  1  evict beat valid
dma_data_yumi_o  out  1  evict beat consumed
app_addr_o  out  app_addr_width_p  MIG address
app_cmd_o  out  3  3'b000 write, 3'b001 read
app_en_o  out  1  command valid
app_rdy_i  in  1  command accepted
app_wdf_data_o  out  app_data_width_p  write data
app_wdf_mask_o  out  app_data_width_p/8  byte mask, always 0
app_wdf_wren_o  out  1  write data valid
app_wdf_end_o  out  1  equals app_wdf_wren_o
app_wdf_rdy_i  in  1  write data accepted
app_rd_data_i  in  app_data_width_p  read data
app_rd_data_valid_i  in  1  read data valid (no backpressure)
error_o  out  1  sticky protocol error

Behaviour:
Interface:
- One clock (clk_i).
- Reset is synchronous and active-high (reset_i).

Constants:
- D = block_width_p/dma_data_width_p (8).
- A = block_width_p/app_data_width_p (4).
- Base app_addr = (addr with low log2(block_width_p/8) bits zeroed) >> log2(dq_width_p/8), truncated to app_addr_width_p.
- App beat k uses base + k*(app_data_width_p/dq_width_p).
- Buffer bit layout: app beat k = block[128k+:128]; DMA beat j = block[64j+:64]. Beat 0 is the least significant.

Reset:
- state=e_idle; all counters 0; error_o=0.
- All valid, enable and yumi outputs are 0.
- Reset mid-transaction abandons it and discards the buffer.

FSM:
- e_idle:
  - dma_pkt_yumi_o = dma_pkt_v_i & init_calib_complete_i (combinational). Addr and direction are latched on yumi.
  - Write goes to e_wr_fill; read goes to e_rd_req.
- e_wr_fill:
  - dma_data_yumi_o = dma_data_v_i.
  - Each beat is stored at index j, and j++.
  - On beat D-1 accepted, go to e_wr_drain.
  - Back-to-back beats are accepted every cycle.
- e_wr_drain:
  - Command counter c and data counter w run independently.
  - app_en_o=1 while c<A, with cmd write and address for beat c; c++ on app_rdy_i.
  - app_wdf_wren_o=1 while w<A, with data beat w; w++ on app_wdf_rdy_i. Data may lead the command.
  - When both reach A, go to e_idle.
- e_rd_req:
  - app_en_o=1 while c<A, with cmd read; c++ on app_rdy_i.
  - Each app_rd_data_valid_i writes app beat r, and r++.
  - Read data may arrive while commands are still issuing.
  - When beat A-1 is captured, go to e_rd_send.
- e_rd_send:
  - dma_data_v_o=1 with beat j; j++ on dma_data_ready_and_i.
  - After beat D-1 handshakes, go to e_idle.
  - First valid appears the cycle after the last app read beat.

Boundaries and errors:
- app_rd_data_valid_i outside e_rd_req: data is dropped and error_o is set (sticky until reset).
- No new packet is accepted until the current transaction completes.
- Packets are never accepted before calibration completes.
- Ignored inputs per state: dma_data_v_i outside e_wr_fill; dma_data_ready_and_i outside e_rd_send.
- All outputs except the yumis are registered or driven from state/counters.

Decomposition:
- Package mig_dma_app_pkg holds:
  - the dma packet struct {write_not_read, addr};
  - the state enum;
  - the MIG command constants e_mig_cmd_write=3'b000 and e_mig_cmd_read=3'b001.
- Block buffer: inline register array, written per app beat and read per DMA beat.
- Counters: bsg_counter_clear_up instances. No other sub-module is needed.

Test Plan:
- Read at addr 0x8000_0040, calibrated, app_rdy_i=1 -> app_addr 0x0000020, 0x0000028, 0x0000030, 0x0000038 with cmd 001. Return beats 128'h..0F_0E.., 4 beats, 1 cycle apart -> 8 DMA beats, least-significant 64 bits first, all in order.
- Write at 0x0000_0000 with data beats 64'h0..7 -> app_wdf beat0 = {64'h1, 64'h0}, mask 0, end=1. 4 write commands at addresses 0, 8, 16, 24. Returns to idle.
- Write with app_wdf_rdy_i high and app_rdy_i low for 10 cycles -> all 4 data beats drain first, then commands issue. No duplicated or lost beats.
- Packet valid with init_calib_complete_i=0 -> no yumi. Raise calibration -> yumi the same cycle.
- Read with dma_data_ready_and_i toggling 1,0 -> dma_data_o is held stable while stalled; 8 beats complete.
- Reset asserted mid-e_wr_fill after 3 beats -> idle next cycle with all outputs 0. Stray app_rd_data_valid_i in idle -> error_o=1.
